uart_tx_sched: RTL and testbench

- Transmit-side controller for the UART return path of the DDR3 bridge.
- Arbitrates between two byte sources: req0 (DDR3 read-data stream) and req1 (command ack/status bytes).
- Drives the load enable and load data of the external 8-bit TX holding register, then serializes that register's output as 8N1.
- Sits between the memory-command logic and the UART pin.

---
 rtl/uart_tx_sched.sv | 150 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler for the DDR3 bridge return path: arbitrates two
// byte sources, loads the external holding register and sends its contents as 8N1.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-low reset
//   i_req0_*/o_req0_ready  byte source 0 (read-data stream), valid/ready
//   i_req1_*/o_req1_ready  byte source 1 (command ack/status), valid/ready
//   o_load_en/o_load_data  load strobe and data for the external holding register
//   i_reg_data             holding register output, serialized LSB first
//   o_tx                   registered serial line, idle high
//   o_busy                 frame in progress
//   o_done                 one-cycle pulse on the first idle cycle after a stop bit
module uart_tx_sched #(
    parameter int CLKS_PER_BIT = 868,
    parameter int D_WIDTH      = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req0_valid,
    input  logic [D_WIDTH-1:0] i_req0_data,
    output logic               o_req0_ready,
    input  logic               i_req1_valid,
    input  logic [D_WIDTH-1:0] i_req1_data,
    output logic               o_req1_ready,
    output logic               o_load_en,
    output logic [D_WIDTH-1:0] o_load_data,
    input  logic [D_WIDTH-1:0] i_reg_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(D_WIDTH);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_MAX  = IW'(D_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [IW-1:0]   bit_q, bit_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    // 1 means req1 was granted last, so req0 wins the next tie.
    logic            last_q, last_d;

    logic            grant0, grant1;
    logic            ready0, ready1;
    logic            wrap;

    // On a tie the requester that was not served last wins.
    assign grant0 = i_req0_valid && (!i_req1_valid || last_q);
    assign grant1 = i_req1_valid && (!i_req0_valid || !last_q);
    assign wrap   = (baud_q == BAUD_MAX);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q + 1'b1;
        bit_d       = bit_q;
        last_d      = last_q;
        done_d      = 1'b0;
        ready0      = 1'b0;
        ready1      = 1'b0;
        o_load_en   = 1'b0;
        o_load_data = i_req0_data;

        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                ready0 = i_rst && grant0;
                ready1 = i_rst && grant1;
                if (grant1) begin
                    o_load_data = i_req1_data;
                end
                if (ready0 || ready1) begin
                    o_load_en = 1'b1;
                    last_d    = ready1;
                    state_d   = START;
                end
            end
            START: begin
                if (wrap) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (wrap) begin
                    baud_d = '0;
                    if (bit_q == BIT_MAX) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (wrap) begin
                    baud_d  = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line level is derived from the next state so o_tx can be
        // registered yet still change on the same edge as the state.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = i_reg_data[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    assign o_req0_ready = ready0;
    assign o_req1_ready = ready1;
    assign o_tx         = tx_q;
    assign o_busy       = (state_q != IDLE);
    assign o_done       = done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a byte scoreboard checked by a
// serial-line monitor that decodes every frame on o_tx.
module tb_uart_tx_sched;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, v1;
    logic [7:0] d0, d1;
    logic       o_req0_ready, o_req1_ready;
    logic       o_load_en;
    logic [7:0] o_load_data;
    logic [7:0] reg_data = 8'h00;
    logic       o_tx, o_busy, o_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] sb[$];
    int         falls[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External holding register.
    always @(posedge clk) if (o_load_en) reg_data <= o_load_data;

    uart_tx_sched #(
        .CLKS_PER_BIT(CPB),
        .D_WIDTH     (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req0_valid(v0),
        .i_req0_data (d0),
        .o_req0_ready(o_req0_ready),
        .i_req1_valid(v1),
        .i_req1_data (d1),
        .o_req1_ready(o_req1_ready),
        .o_load_en   (o_load_en),
        .o_load_data (o_load_data),
        .i_reg_data  (reg_data),
        .o_tx        (o_tx),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_any(output int who);
        who = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (o_req0_ready) begin who = 0; break; end
            if (o_req1_ready) begin who = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic frame_wait(output int n, output logic bad);
        n   = 0;
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!o_busy) break;
            n++;
            if (o_load_en || o_req0_ready || o_req1_ready) bad = 1'b1;
            @(negedge clk);
        end
    endtask

    // Line monitor: on each falling edge from idle, pop the expected byte and
    // check every cycle of the 10-bit frame plus the mid-bit samples.
    initial begin : monitor
        logic       act;
        logic       prev;
        logic       glitch;
        logic [9:0] mexp, mobs;
        logic [7:0] b;
        int         mc;
        act  = 1'b0;
        prev = 1'b1;
        mc   = 0;
        glitch = 1'b0;
        mexp = '1;
        mobs = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                act = 1'b0;
            end else if (!act && prev && !o_tx) begin
                act    = 1'b1;
                mc     = 0;
                glitch = 1'b0;
                mobs   = '0;
                falls.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                    mexp = '1;
                end else begin
                    b    = sb.pop_front();
                    mexp = {1'b1, b, 1'b0};
                end
            end
            if (act) begin
                if (o_tx !== mexp[mc/CPB]) glitch = 1'b1;
                if (mc % CPB == CPB / 2) mobs[mc/CPB] = o_tx;
                mc++;
                if (mc == 10 * CPB) begin
                    chk("frame_bits", 32'(mobs), 32'(mexp));
                    chk("frame_steady", 32'(glitch), 0);
                    act = 1'b0;
                end
            end
            prev = o_tx;
        end
    end

    initial begin : stim
        int         who, n, pd;
        logic       bad;
        logic [7:0] fb[4];
        fb[0] = 8'h31; fb[1] = 8'h32; fb[2] = 8'h33; fb[3] = 8'h34;

        rst = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        d0 = 8'h00; d1 = 8'h00;

        // Reset state, and no ready while reset is held.
        repeat (3) @(negedge clk);
        v0 = 1'b1; d0 = 8'hEE;
        #1;
        chk("rst_tx", 32'(o_tx), 1);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_ready0", 32'(o_req0_ready), 0);
        chk("rst_load_en", 32'(o_load_en), 0);
        @(negedge clk);
        v0 = 1'b0;
        rst = 1'b1;

        // Single byte 0xA5 from req0.
        @(negedge clk);
        sb.push_back(8'hA5);
        v0 = 1'b1; d0 = 8'hA5;
        wait_any(who);
        chk("t1_grant", who, 0);
        chk("t1_load_en", 32'(o_load_en), 1);
        chk("t1_load_data", 32'(o_load_data), 32'hA5);
        @(negedge clk);
        v0 = 1'b0;
        frame_wait(n, bad);
        chk("t1_busy_len", n, 40);
        chk("t1_no_mid_load", 32'(bad), 0);
        chk("t1_done", 32'(o_done), 1);
        @(negedge clk);
        #1;
        chk("t1_done_clear", 32'(o_done), 0);

        // Simultaneous request after reset: req0 first, req1 in done cycle.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        falls.delete();
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        v0 = 1'b1; d0 = 8'h11;
        v1 = 1'b1; d1 = 8'h22;
        wait_any(who);
        chk("t2_grant0", who, 0);
        chk("t2_data0", 32'(o_load_data), 32'h11);
        @(negedge clk);
        v0 = 1'b0;
        frame_wait(n, bad);
        wait_any(who);
        chk("t2_grant1", who, 1);
        chk("t2_done_grant", 32'(o_done), 1);
        chk("t2_data1", 32'(o_load_data), 32'h22);
        @(negedge clk);
        v1 = 1'b0;
        frame_wait(n, bad);
        pd = (falls.size() >= 2) ? falls[1] - falls[0] : -1;
        chk("t2_period", pd, 41);

        // Fairness: both valid for four frames, grants alternate from req0.
        @(negedge clk);
        for (int k = 0; k < 4; k++) sb.push_back(fb[k]);
        v0 = 1'b1; d0 = 8'h31;
        v1 = 1'b1; d1 = 8'h32;
        for (int k = 0; k < 4; k++) begin
            wait_any(who);
            chk("t3_grant", who, k % 2);
            chk("t3_data", 32'(o_load_data), 32'(fb[k]));
            @(negedge clk);
            if (who == 0) begin
                if (d0 == 8'h31) d0 = 8'h33;
                else v0 = 1'b0;
            end else if (who == 1) begin
                if (d1 == 8'h32) d1 = 8'h34;
                else v1 = 1'b0;
            end
            frame_wait(n, bad);
            chk("t3_len", n, 40);
        end

        // Single requester back to back: req0 wins every frame.
        falls.delete();
        v1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(8'h41 + 8'(k));
            d0 = 8'h41 + 8'(k);
            v0 = 1'b1;
            wait_any(who);
            chk("t4_grant", who, 0);
            chk("t4_data", 32'(o_load_data), 32'(8'h41 + 8'(k)));
            if (k > 0) chk("t4_done_grant", 32'(o_done), 1);
            @(negedge clk);
            if (k == 2) v0 = 1'b0;
            frame_wait(n, bad);
        end
        pd = (falls.size() >= 3) ? falls[2] - falls[1] : -1;
        chk("t4_period", pd, 41);

        // Reset during data bit 3.
        @(negedge clk);
        sb.push_back(8'h5A);
        v0 = 1'b1; d0 = 8'h5A;
        wait_any(who);
        chk("t5_grant", who, 0);
        @(negedge clk);
        v0 = 1'b0;
        repeat (16) @(negedge clk);
        #1;
        chk("t5_pre_tx", 32'(o_tx), 1);
        chk("t5_pre_busy", 32'(o_busy), 1);
        rst = 1'b0;
        v1 = 1'b1; d1 = 8'h3C;
        @(negedge clk);
        #1;
        chk("t5_rst_tx", 32'(o_tx), 1);
        chk("t5_rst_busy", 32'(o_busy), 0);
        chk("t5_rst_done", 32'(o_done), 0);
        chk("t5_rst_ready1", 32'(o_req1_ready), 0);
        @(negedge clk);
        #1;
        chk("t5_rst_done2", 32'(o_done), 0);
        rst = 1'b1;
        sb.push_back(8'h3C);
        wait_any(who);
        chk("t5_grant1", who, 1);
        chk("t5_data", 32'(o_load_data), 32'h3C);
        @(negedge clk);
        v1 = 1'b0;
        frame_wait(n, bad);
        chk("t5_len", n, 40);
        chk("t5_done", 32'(o_done), 1);

        // Valid raised mid-frame waits for the idle cycle.
        @(negedge clk);
        sb.push_back(8'h77);
        sb.push_back(8'h66);
        v1 = 1'b1; d1 = 8'h77;
        wait_any(who);
        chk("t6_grant1", who, 1);
        @(negedge clk);
        v1 = 1'b0;
        repeat (5) @(negedge clk);
        v0 = 1'b1; d0 = 8'h66;
        frame_wait(n, bad);
        chk("t6_gate_len", n, 35);
        chk("t6_no_mid_ready", 32'(bad), 0);
        wait_any(who);
        chk("t6_grant0", who, 0);
        chk("t6_done_grant", 32'(o_done), 1);
        chk("t6_data", 32'(o_load_data), 32'h66);
        @(negedge clk);
        v0 = 1'b0;
        frame_wait(n, bad);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
